mem_responder: RTL and testbench

Memory-side responder for the CPU's instruction and data memory ports. It serves both request ports from one single-port word-organised SRAM. Data accesses have priority over instruction accesses. Both ready outputs are released together in one completion cycle, because the CPU pipeline only advances when both readies are high. It sits between the CPU core and on-chip memory, with a parameterised number of wait states so that slow memories can be modelled.

---
 rtl/mem_pkg.sv | 19 +
 rtl/sram_1p.sv | 42 ++++
 rtl/mem_responder.sv | 160 ++++++++++++++++
 tb/tb_mem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory responder.
//   state_e     - responder FSM state encoding (2 bits)
//   wait_cnt_t  - wait-state counter type (WAIT_CNT_W bits)
//   WAIT_STATES_MAX - largest supported number of extra access cycles
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DATA_ACC  = 2'd1,
        ST_INSTR_ACC = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    localparam int unsigned WAIT_CNT_W      = 4;
    localparam int unsigned WAIT_STATES_MAX = 15;

    typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/sram_1p.sv
// sram_1p: single-port, word-organised 32-bit SRAM model.
//   clk   - clock, all accesses on the rising edge
//   en    - access enable
//   we    - write enable (with en); otherwise the access is a read
//   be    - byte-lane write enables, bit n covers wdata[8n+7:8n]
//   addr  - word address
//   wdata - write data
//   rdata - registered read data, held until the next enabled read
module sram_1p
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter              INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: serves the CPU instruction and data ports from one
// single-port SRAM. Data accesses go first; both readies are raised
// together for exactly one cycle when the whole request set is served.
//   clk_i, rst_i              - clock, asynchronous active-low reset
//   instr_mem_rd_i/addr_i     - instruction fetch request / byte address
//   instr_mem_data_o/ready_o  - fetched word / ready
//   data_mem_rd_i/wr_i        - data read / write request (both = write)
//   data_mem_addr_i/data_i    - data byte address / lane-aligned write data
//   byte_select_i             - write byte enables
//   data_mem_data_o/ready_o   - read word / ready
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_STATES = 0,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_mem_rd_i,
    input  logic [31:0] instr_mem_addr_i,
    output logic [31:0] instr_mem_data_o,
    output logic        instr_mem_ready_o,
    input  logic        data_mem_rd_i,
    input  logic        data_mem_wr_i,
    input  logic [31:0] data_mem_addr_i,
    input  logic [31:0] data_mem_data_i,
    input  logic [3:0]  byte_select_i,
    output logic [31:0] data_mem_data_o,
    output logic        data_mem_ready_o
);

    localparam wait_cnt_t WAIT_LOAD = wait_cnt_t'(WAIT_STATES);

    state_e    state_q, state_d;
    wait_cnt_t cnt_q, cnt_d;
    logic      first_q, first_d;
    logic [31:0] instr_hold_q, instr_hold_d;
    logic [31:0] data_hold_q, data_hold_d;

    logic                  data_req, instr_req, acc_last;
    logic                  sram_en, sram_we, ready;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [31:0]           sram_rdata;
    logic                  unused_addr_bits;

    assign data_req  = data_mem_rd_i | data_mem_wr_i;
    assign instr_req = instr_mem_rd_i;

    // An ACC state is one enable cycle (first_q) followed by WAIT_STATES+1
    // countdown cycles, so the counter never has to hold WAIT_STATES+1.
    assign acc_last = !first_q && (cnt_q == '0);

    assign unused_addr_bits = ^{instr_mem_addr_i[31:ADDR_WIDTH+2], instr_mem_addr_i[1:0],
                                data_mem_addr_i[31:ADDR_WIDTH+2], data_mem_addr_i[1:0]};

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            first_q      <= 1'b0;
            instr_hold_q <= '0;
            data_hold_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            instr_hold_q <= instr_hold_d;
            data_hold_q  <= data_hold_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        unique case (state_q)
            ST_IDLE: begin
                if (data_req) begin
                    state_d = ST_DATA_ACC;
                    cnt_d   = WAIT_LOAD;
                    first_d = 1'b1;
                end else if (instr_req) begin
                    state_d = ST_INSTR_ACC;
                    cnt_d   = WAIT_LOAD;
                    first_d = 1'b1;
                end
            end
            ST_DATA_ACC: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (cnt_q == '0) begin
                    if (instr_req) begin
                        state_d = ST_INSTR_ACC;
                        cnt_d   = WAIT_LOAD;
                        first_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_INSTR_ACC: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        sram_en      = first_q && ((state_q == ST_DATA_ACC) || (state_q == ST_INSTR_ACC));
        sram_we      = (state_q == ST_DATA_ACC) && data_mem_wr_i;
        sram_addr    = (state_q == ST_INSTR_ACC) ? instr_mem_addr_i[ADDR_WIDTH+1:2]
                                                 : data_mem_addr_i[ADDR_WIDTH+1:2];
        instr_hold_d = instr_hold_q;
        data_hold_d  = data_hold_q;
        if ((state_q == ST_INSTR_ACC) && acc_last) begin
            instr_hold_d = sram_rdata;
        end
        if ((state_q == ST_DATA_ACC) && acc_last && !data_mem_wr_i) begin
            data_hold_d = sram_rdata;
        end
        ready = (state_q == ST_DONE) ||
                ((state_q == ST_IDLE) && !data_req && !instr_req);
    end

    assign instr_mem_ready_o = ready;
    assign data_mem_ready_o  = ready;
    assign instr_mem_data_o  = instr_hold_q;
    assign data_mem_data_o   = data_hold_q;

    sram_1p #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_sram (
        .clk   (clk_i),
        .en    (sram_en),
        .we    (sram_we),
        .be    (byte_select_i),
        .addr  (sram_addr),
        .wdata (data_mem_data_i),
        .rdata (sram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder (ADDR_WIDTH=4, two
// wait states). A transaction-level model predicts ready timing and the
// returned words; a compare process checks them every cycle.
module tb_mem_responder;

    localparam int unsigned AW  = 4;
    localparam int unsigned W   = 2;
    localparam int unsigned ACC = 2 + W;

    logic        clk;
    logic        rst_i;
    logic        instr_mem_rd_i;
    logic [31:0] instr_mem_addr_i;
    logic [31:0] instr_mem_data_o;
    logic        instr_mem_ready_o;
    logic        data_mem_rd_i;
    logic        data_mem_wr_i;
    logic [31:0] data_mem_addr_i;
    logic [31:0] data_mem_data_i;
    logic [3:0]  byte_select_i;
    logic [31:0] data_mem_data_o;
    logic        data_mem_ready_o;

    mem_responder #(
        .ADDR_WIDTH  (AW),
        .WAIT_STATES (W),
        .INIT_FILE   ("")
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .instr_mem_rd_i    (instr_mem_rd_i),
        .instr_mem_addr_i  (instr_mem_addr_i),
        .instr_mem_data_o  (instr_mem_data_o),
        .instr_mem_ready_o (instr_mem_ready_o),
        .data_mem_rd_i     (data_mem_rd_i),
        .data_mem_wr_i     (data_mem_wr_i),
        .data_mem_addr_i   (data_mem_addr_i),
        .data_mem_data_i   (data_mem_data_i),
        .byte_select_i     (byte_select_i),
        .data_mem_data_o   (data_mem_data_o),
        .data_mem_ready_o  (data_mem_ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] model_mem [0:(1<<AW)-1];
    logic [31:0] exp_i, exp_d;
    logic        exp_ready;
    logic        chk_en;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        logic [AW-1:0] w;
        w = a[AW+1:2];
        return int'(w);
    endfunction

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_ready", {31'b0, instr_mem_ready_o}, {31'b0, exp_ready});
            check("data_ready",  {31'b0, data_mem_ready_o},  {31'b0, exp_ready});
            if (exp_ready) begin
                check("instr_data", instr_mem_data_o, exp_i);
                check("data_data",  data_mem_data_o,  exp_d);
            end
        end
    end

    task automatic idle_inputs();
        instr_mem_rd_i   = 1'b0;
        instr_mem_addr_i = '0;
        data_mem_rd_i    = 1'b0;
        data_mem_wr_i    = 1'b0;
        data_mem_addr_i  = '0;
        data_mem_data_i  = '0;
        byte_select_i    = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 of the first cycle after DONE.
    task automatic txn(input logic ird, input logic [31:0] ia,
                       input logic drd, input logic dwr, input logic [31:0] da,
                       input logic [31:0] wd, input logic [3:0] be);
        int unsigned n, lat;
        instr_mem_rd_i   = ird;
        instr_mem_addr_i = ia;
        data_mem_rd_i    = drd;
        data_mem_wr_i    = dwr;
        data_mem_addr_i  = da;
        data_mem_data_i  = wd;
        byte_select_i    = be;
        n   = ((drd | dwr) ? 1 : 0) + (ird ? 1 : 0);
        lat = (n == 0) ? 0 : 1 + n * ACC;
        for (int unsigned k = 0; k <= lat; k++) begin
            if (k == lat) begin
                // data side is served first, so a fetch sees a same-request write
                if (drd | dwr) begin
                    if (dwr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (be[b]) model_mem[widx(da)][8*b +: 8] = wd[8*b +: 8];
                        end
                    end else begin
                        exp_d = model_mem[widx(da)];
                    end
                end
                if (ird) exp_i = model_mem[widx(ia)];
            end
            exp_ready = (k == lat);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        exp_ready = 1'b1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        txn(1'b0, 32'h0, 1'b0, 1'b1, a, d, be);
    endtask

    task automatic rd(input logic [31:0] a);
        txn(1'b0, 32'h0, 1'b1, 1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic fetch(input logic [31:0] a);
        txn(1'b1, a, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        chk_en    = 1'b0;
        exp_ready = 1'b1;
        exp_i     = '0;
        exp_d     = '0;
        for (int i = 0; i < (1 << AW); i++) model_mem[i] = '0;
        idle_inputs();
        rst_i = 1'b1;
        #2 rst_i = 1'b0;
        #1;
        check("rst_ready",      {31'b0, instr_mem_ready_o}, 32'd1);
        check("rst_instr_data", instr_mem_data_o, 32'h0);
        check("rst_data_data",  data_mem_data_o,  32'h0);
        @(posedge clk);
        #1 rst_i = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // preload through the write path
        wr(32'h4, 32'h00500093, 4'hF);
        wr(32'h8, 32'h11111111, 4'hF);

        // instruction fetch only
        fetch(32'h4);
        check("fetch_0x4", instr_mem_data_o, 32'h00500093);

        // simultaneous data read and fetch, data served first
        wr(32'h100, 32'hDEADBEEF, 4'hF);
        txn(1'b1, 32'h8, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        check("sim_instr", instr_mem_data_o, 32'h11111111);
        check("sim_data",  data_mem_data_o,  32'hDEADBEEF);

        // byte-lane write
        wr(32'h40, 32'hAABBCCDD, 4'hF);
        wr(32'h40, 32'h00001200, 4'b0010);
        rd(32'h40);
        check("byte_write", data_mem_data_o, 32'hAABB12DD);

        // address wrap
        wr(32'h40, 32'hCAFEF00D, 4'hF);
        rd(32'h0);
        check("wrap_0x0", data_mem_data_o, 32'hCAFEF00D);
        txn(1'b1, 32'hFFFFFFC4, 1'b1, 1'b0, 32'hFFFFFF80, 32'h0, 4'h0);
        check("wrap_hi_instr", instr_mem_data_o, 32'h00500093);
        check("wrap_hi_data",  data_mem_data_o,  32'hCAFEF00D);

        // rd and wr together act as a write; hold keeps the old read word
        txn(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
        check("rdwr_hold", data_mem_data_o, 32'hCAFEF00D);
        rd(32'h20);
        check("rdwr_read", data_mem_data_o, 32'h12345678);

        // write plus fetch of the same word: fetch sees new data
        txn(1'b1, 32'h24, 1'b0, 1'b1, 32'h24, 32'h0BADF00D, 4'hF);
        check("wr_then_fetch", instr_mem_data_o, 32'h0BADF00D);

        // no requests: readies stay high
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end

        // reset in the middle of an instruction access
        instr_mem_rd_i   = 1'b1;
        instr_mem_addr_i = 32'h8;
        exp_ready        = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        rst_i  = 1'b0;
        #1;
        check("mid_rst_ready",      {31'b0, instr_mem_ready_o}, 32'd0);
        check("mid_rst_instr_data", instr_mem_data_o, 32'h0);
        check("mid_rst_data_data",  data_mem_data_o,  32'h0);
        instr_mem_rd_i = 1'b0;
        #1;
        check("mid_rst_idle_ready", {31'b0, data_mem_ready_o}, 32'd1);
        instr_mem_rd_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i  = 1'b1;
        exp_i  = '0;
        exp_d  = '0;
        chk_en = 1'b1;
        fetch(32'h8);
        check("post_rst_fetch", instr_mem_data_o, 32'h11111111);
        rd(32'h4);
        check("post_rst_read", data_mem_data_o, 32'h00500093);

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
